// File: rtl/vext_pkg.sv
// ============================================================================
// vext_pkg : encodings, FSM state type and beat-count helper for vext_unit
// Revision : 1.0
// ============================================================================
`default_nettype none

package vext_pkg;

  localparam logic [1:0] SEW_8  = 2'd0;
  localparam logic [1:0] SEW_16 = 2'd1;
  localparam logic [1:0] SEW_32 = 2'd2;
  localparam logic [1:0] SEW_64 = 2'd3;

  localparam logic [1:0] FRAC_BCAST = 2'd0;
  localparam logic [1:0] FRAC_VF2   = 2'd1;
  localparam logic [1:0] FRAC_VF4   = 2'd2;
  localparam logic [1:0] FRAC_VF8   = 2'd3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic [2:0] last_idx;
    logic       err;
  } beat_plan_t;

  // Control fields captured alongside the source beat
  typedef struct packed {
    logic [1:0] sew;
    logic [1:0] frac;
    logic       sgn;
    logic       imm;
    logic       last;
    logic [2:0] last_idx;
    logic       err;
  } ctrl_t;

  // A vfN source element narrower than 8 bits has no encoding
  function automatic beat_plan_t plan_beats(input logic [1:0] sew, input logic [1:0] frac);
    beat_plan_t p;
    p.err      = (frac != FRAC_BCAST) && (frac > sew);
    p.last_idx = (p.err || (frac == FRAC_BCAST)) ? 3'd0 : 3'((4'd1 << frac) - 4'd1);
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vext_if.sv
// ============================================================================
// vext_if : source/result valid-ready bundle between VRF read and ALU mux
// Revision : 1.0
// ============================================================================
`default_nettype none

interface vext_if #(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_sew;
  logic [1:0]        in_frac;
  logic              in_signed;
  logic              in_imm;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_err;

  modport master (
    output in_valid, in_data, in_sew, in_frac, in_signed, in_imm, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_err
  );

  modport slave (
    input  in_valid, in_data, in_sew, in_frac, in_signed, in_imm, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_err
  );
endinterface

`default_nettype wire

// File: rtl/vext_slice.sv
// ============================================================================
// vext_slice : builds one extended output beat from the held source beat
// Revision : 1.0
// ============================================================================
`default_nettype none

module vext_slice
  import vext_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int SCALAR_W = 32
) (
  input  logic [DATA_W-1:0] src,
  input  logic [1:0]        sew,
  input  logic [1:0]        frac,
  input  logic [2:0]        beat,
  input  logic              sgn,
  input  logic              imm,
  input  logic              err,
  output logic [DATA_W-1:0] dst
);

  localparam int NBYTES = DATA_W / 8;

  logic [63:0] bcast_val;

  always_comb begin
    if (imm) begin
      bcast_val = {{59{sgn & src[4]}}, src[4:0]};
    end else begin
      bcast_val = {{(64-SCALAR_W){sgn & src[SCALAR_W-1]}}, src[SCALAR_W-1:0]};
    end
  end

  // Every legal source element is a whole number of bytes, so the beat is
  // assembled byte by byte: copy a source byte or replicate its top bit.
  always_comb begin
    int t;
    int elem;
    int sw_bytes;
    int base;
    t        = 0;
    elem     = 0;
    sw_bytes = 0;
    base     = 0;
    dst      = '0;
    if (!err) begin
      for (int b = 0; b < NBYTES; b++) begin
        t    = b & ((1 << int'(sew)) - 1);
        elem = b >> int'(sew);
        if (frac == FRAC_BCAST) begin
          dst[b*8 +: 8] = bcast_val[t*8 +: 8];
        end else begin
          sw_bytes = (1 << int'(sew)) >> int'(frac);
          base     = int'(beat) * (NBYTES >> int'(frac)) + elem * sw_bytes;
          if (t < sw_bytes) begin
            dst[b*8 +: 8] = src[(base + t)*8 +: 8];
          end else begin
            dst[b*8 +: 8] = {8{sgn & src[(base + sw_bytes)*8 - 1]}};
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vext_unit.sv
// ============================================================================
// vext_unit : pipelined vsext/vzext and scalar/simm5 broadcast extender
// Revision : 1.0
// ============================================================================
`default_nettype none

module vext_unit
  import vext_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int SCALAR_W = 32
) (
  input  logic   clk,
  input  logic   rst,
  vext_if.slave  bus
);

  state_e            state_q, state_d;
  logic [2:0]        beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  ctrl_t             ctrl_q, ctrl_d;

  beat_plan_t        plan;
  logic              accept;
  logic              fire;
  logic              last_beat;
  logic [DATA_W-1:0] slice_data;

  assign plan      = plan_beats(bus.in_sew, bus.in_frac);
  assign last_beat = (beat_cnt_q == ctrl_q.last_idx);
  assign fire      = bus.out_valid && bus.out_ready;
  assign accept    = bus.in_valid && bus.in_ready;

  // Accepting on the final handshake keeps back-to-back beats bubble-free
  assign bus.in_ready  = !rst && ((state_q == IDLE) || (fire && last_beat));
  assign bus.out_valid = (state_q == BUSY);
  assign bus.out_data  = (state_q == BUSY) ? slice_data : '0;
  assign bus.out_last  = (state_q == BUSY) && ctrl_q.last && last_beat;
  assign bus.out_err   = (state_q == BUSY) && ctrl_q.err;

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    hold_data_d = hold_data_q;
    ctrl_d      = ctrl_q;
    case (state_q)
      IDLE: begin
        beat_cnt_d = 3'd0;
      end
      BUSY: begin
        if (fire) begin
          if (last_beat) begin
            state_d    = IDLE;
            beat_cnt_d = 3'd0;
          end else begin
            beat_cnt_d = beat_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d         = BUSY;
      beat_cnt_d      = 3'd0;
      hold_data_d     = bus.in_data;
      ctrl_d.sew      = bus.in_sew;
      ctrl_d.frac     = bus.in_frac;
      ctrl_d.sgn      = bus.in_signed;
      ctrl_d.imm      = bus.in_imm;
      ctrl_d.last     = bus.in_last;
      ctrl_d.last_idx = plan.last_idx;
      ctrl_d.err      = plan.err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_cnt_q  <= 3'd0;
      hold_data_q <= '0;
      ctrl_q      <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      hold_data_q <= hold_data_d;
      ctrl_q      <= ctrl_d;
    end
  end

  vext_slice #(
    .DATA_W   (DATA_W),
    .SCALAR_W (SCALAR_W)
  ) u_slice (
    .src  (hold_data_q),
    .sew  (ctrl_q.sew),
    .frac (ctrl_q.frac),
    .beat (beat_cnt_q),
    .sgn  (ctrl_q.sgn),
    .imm  (ctrl_q.imm),
    .err  (ctrl_q.err),
    .dst  (slice_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_vext_unit.sv
// ============================================================================
// tb_vext_unit : directed vectors with a queue scoreboard for vext_unit
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vext_unit;

  localparam int DATA_W = 64;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic              err;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   beat_no;
  exp_t exp_q[$];

  vext_if #(.DATA_W(DATA_W)) bus ();

  vext_unit #(
    .DATA_W   (DATA_W),
    .SCALAR_W (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] data, input logic last, input logic err);
    exp_t e;
    e.data = data;
    e.last = last;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  // Monitor: every output handshake is checked against the queue head
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got data 0x%0h with nothing expected", bus.out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("beat%0d_data", beat_no), bus.out_data, e.data);
        chk($sformatf("beat%0d_last", beat_no), DATA_W'(bus.out_last), DATA_W'(e.last));
        chk($sformatf("beat%0d_err", beat_no), DATA_W'(bus.out_err), DATA_W'(e.err));
      end
      beat_no++;
    end
  end

  task automatic send(input logic [DATA_W-1:0] data, input logic [1:0] sew, input logic [1:0] frac,
                      input logic sgn, input logic imm, input logic last);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.in_data   = data;
    bus.in_sew    = sew;
    bus.in_frac   = frac;
    bus.in_signed = sgn;
    bus.in_imm    = imm;
    bus.in_last   = last;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", n);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    bad = 0;
    beat_no = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sew    = 2'd0;
    bus.in_frac   = 2'd0;
    bus.in_signed = 1'b0;
    bus.in_imm    = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", DATA_W'(bus.in_ready), '0);
    chk("rst_out_valid", DATA_W'(bus.out_valid), '0);
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_out_last", DATA_W'(bus.out_last), '0);
    chk("rst_out_err", DATA_W'(bus.out_err), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", DATA_W'(bus.in_ready), DATA_W'(1));

    // vsext.vf2, sew=16
    push(64'h0000_0000_FF80_007F, 1'b0, 1'b0);
    push(64'h0, 1'b0, 1'b0);
    send(64'h0000_0000_0000_807F, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0);
    chk("latency_out_valid", DATA_W'(bus.out_valid), DATA_W'(1));
    drain();

    // vzext.vf8, sew=64, last only on beat 7
    push(64'h0000_0000_0000_00FF, 1'b0, 1'b0);
    push(64'h0000_0000_0000_0080, 1'b0, 1'b0);
    for (int k = 2; k < 8; k++) push(64'h0, (k == 7), 1'b0);
    send(64'h0000_0000_0000_80FF, 2'd3, 2'd3, 1'b0, 1'b0, 1'b1);
    drain();

    // Broadcast simm5 0x16 signed, sew=32 (upper bits are junk)
    push(64'hFFFF_FFF6_FFFF_FFF6, 1'b1, 1'b0);
    send(64'hABCD_0000_1234_5676, 2'd2, 2'd0, 1'b1, 1'b1, 1'b1);
    drain();

    // Broadcast scalar 0x80000001: signed sew=64, zero sew=16, signed sew=8
    push(64'hFFFF_FFFF_8000_0001, 1'b0, 1'b0);
    send(64'hDEAD_BEEF_8000_0001, 2'd3, 2'd0, 1'b1, 1'b0, 1'b0);
    drain();
    push(64'h0001_0001_0001_0001, 1'b0, 1'b0);
    send(64'hDEAD_BEEF_8000_0001, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
    drain();
    push(64'h0101_0101_0101_0101, 1'b0, 1'b0);
    send(64'hDEAD_BEEF_8000_0001, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    drain();

    // vsext.vf4, sew=32, stalled on beat1, next input overlaps beat3
    push(64'h0000_0001_0000_0002, 1'b0, 1'b0);
    push(64'hFFFF_FF80_FFFF_FFFF, 1'b0, 1'b0);
    push(64'h0000_007F_0000_0002, 1'b0, 1'b0);
    push(64'hFFFF_FF80_0000_0001, 1'b0, 1'b0);
    send(64'h8001_7F02_80FF_0102, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_out_valid", DATA_W'(bus.out_valid), DATA_W'(1));
      chk("stall_out_data", bus.out_data, 64'hFFFF_FF80_FFFF_FFFF);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    push(64'hFFFF_FFFF_8000_0001, 1'b0, 1'b0);
    bus.in_valid  = 1'b1;
    bus.in_data   = 64'h0000_0000_8000_0001;
    bus.in_sew    = 2'd3;
    bus.in_frac   = 2'd0;
    bus.in_signed = 1'b1;
    bus.in_imm    = 1'b0;
    bus.in_last   = 1'b0;
    @(negedge clk);
    chk("overlap_in_ready", DATA_W'(bus.in_ready), DATA_W'(1));
    chk("overlap_beat3_data", bus.out_data, 64'hFFFF_FF80_0000_0001);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("no_bubble_out_valid", DATA_W'(bus.out_valid), DATA_W'(1));
    chk("no_bubble_out_data", bus.out_data, 64'hFFFF_FFFF_8000_0001);
    drain();

    // Illegal: sew=8 with vf2
    push(64'h0, 1'b1, 1'b1);
    send(64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 2'd1, 1'b1, 1'b0, 1'b1);
    drain();
    @(negedge clk);
    chk("illegal_then_in_ready", DATA_W'(bus.in_ready), DATA_W'(1));

    // Reset during beat2 of vf8
    push(64'h0000_0000_0000_00FF, 1'b0, 1'b0);
    push(64'h0000_0000_0000_0080, 1'b0, 1'b0);
    send(64'h0000_0000_0000_80FF, 2'd3, 2'd3, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_out_valid", DATA_W'(bus.out_valid), '0);
    chk("abort_in_ready", DATA_W'(bus.in_ready), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_release_in_ready", DATA_W'(bus.in_ready), DATA_W'(1));
    repeat (10) begin
      @(negedge clk);
      chk("abort_no_beats", DATA_W'(bus.out_valid), '0);
    end

    // Recovery: broadcast simm5 zero-extended, sew=8
    push(64'h1616_1616_1616_1616, 1'b0, 1'b0);
    send(64'h0000_0000_0000_0036, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    drain();

    chk("queue_drained", DATA_W'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vext_unit.md
Name: vext_unit

Overview:
- Pipelined operand-extension engine for the vector execute stage.
- Implements vsext/vzext .vf2/.vf4/.vf8: each DATA_W-bit source beat is widened into N destination beats.
- Also provides scalar/simm5 sign/zero extension with broadcast across a beat, generalising the fixed 64-bit immediate/scalar extender to any SEW and DATA_W.
- Valid/ready on both sides; sits between the VRF read port and the ALU operand mux.

Parameters:
DATA_W, 64, beat width in bits; multiple of 64
SCALAR_W, 32, scalar operand width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  source beat valid
in_ready  output  1  unit can accept a beat
in_data  input  DATA_W  source elements; scalar in [SCALAR_W-1:0], simm5 in [4:0]
in_sew  input  2  destination SEW: 0=8, 1=16, 2=32, 3=64
in_frac  input  2  0=broadcast, 1=vf2, 2=vf4, 3=vf8
in_signed  input  1  1=sign-extend, 0=zero-extend
in_imm  input  1  broadcast source is simm5 (1) or scalar (0)
in_last  input  1  final beat of register group
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts beat
out_data  output  DATA_W  extended elements
out_last  output  1  in_last echoed on final output beat
out_err  output  1  illegal SEW/frac combination

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset values:
  - out_valid=0, out_data=0, out_last=0, out_err=0.
  - in_ready=0 while rst is high, 1 in the first cycle after deassertion.
  - beat_cnt=0, state=IDLE.
- Capture: on in_valid&&in_ready, in_data and all control inputs are registered into a hold register.
  - Latency: out_valid rises the cycle after acceptance.
- FSM IDLE -> BUSY on accept.
  - In BUSY, out_valid=1 and out_data is derived from the hold register and beat_cnt.
  - On out_valid&&out_ready: beat_cnt++. When beat_cnt==N-1, go to IDLE, or stay in BUSY with beat_cnt=0 if a new beat is accepted in the same cycle.
- in_ready = IDLE || (out_valid && out_ready && beat_cnt==N-1). Back-to-back beats run with no bubble.
- N (beats per input): vf2=2, vf4=4, vf8=8; broadcast and illegal = 1.
- vfN arithmetic:
  - src width = SEW/N; E = DATA_W/SEW elements per output beat.
  - Output beat k, element i = ext(src element k*E+i).
  - Extension is sign- or zero-extension per in_signed.
- Broadcast:
  - Source value: in_imm=1 selects in_data[4:0] (5-bit); otherwise in_data[SCALAR_W-1:0].
  - The value is extended to SEW, or truncated to its low SEW bits when SEW<source width.
  - It is replicated DATA_W/SEW times.
  - SEW=64 scalar yields {32{sign}},scalar.
- Illegal combinations: SEW/N<8, i.e. sew=8 with any vfN, sew=16 with vf4/vf8, sew=32 with vf8.
  - Produces one beat with out_data=0, out_err=1.
  - out_err is 0 on all legal beats.
- out_last=1 only on beat N-1 of a beat captured with in_last=1.
- Backpressure: while out_valid&&!out_ready, out_data/out_last/out_err/beat_cnt are held stable.
- Reset mid-operation aborts: the in-flight beat is dropped, out_valid=0 the cycle after rst is sampled high, and no partial beats are emitted afterwards.

Decomposition:
- Package vext_pkg holds:
  - SEW and FRAC encodings
  - state enum {IDLE, BUSY}
  - a function mapping (sew, frac) to N and an illegal flag
- Sub-module vext_slice (combinational) maps (hold data, sew, frac, beat_cnt, signed, broadcast fields) to one out_data beat.
- The top level holds the FSM, hold register, counter and handshake.

Test Plan:
- vsext.vf2, sew=16, in_data=0x000000000000807F -> beat0 0x00000000FF80007F, beat1 0x0; out_err=0.
- vzext.vf8, sew=64, in_data=0x00000000000080FF -> beat0 0x00000000000000FF, beat1 0x0000000000000080, beats2-7 0x0.
- Broadcast, in_imm=1, simm5=0x16, signed, sew=32, in_last=1 -> single beat 0xFFFFFFF6FFFFFFF6 with out_last=1.
- Broadcast, scalar 0x80000001, signed, sew=64 -> 0xFFFFFFFF80000001.
- Broadcast, same scalar, zero-extend, sew=16 -> 0x0001000100010001.
- vsext.vf4, sew=32, out_ready low 3 cycles on beat1 -> beat1 stable during the stall.
  - A second input presented during beat3 is accepted in the beat3 handshake cycle.
  - Its beat0 follows the next cycle (no bubble).
- Illegal: sew=8 with vf2 -> one beat, out_data=0, out_err=1, then in_ready=1.
- Reset asserted during beat2 of vf8 -> out_valid=0 the next cycle, no further beats, in_ready=1 after release.
